// File: rtl/rect_rasterizer.sv
// Filled-rectangle fragment generator: clips accepted rectangles to the screen,
// scans them row-major at one fragment per cycle and orders buffer swaps after them.
module rect_rasterizer #(
  parameter int WIDTH  = 320,
  parameter int HEIGHT = 240
) (
  input  logic        gpu_clk_in,
  input  logic        rst_in,
  input  logic        cmd_valid_in,
  output logic        cmd_ready_out,
  input  logic [8:0]  cmd_x0_in,
  input  logic [8:0]  cmd_x1_in,
  input  logic [7:0]  cmd_y0_in,
  input  logic [7:0]  cmd_y1_in,
  input  logic [7:0]  cmd_z_in,
  input  logic [11:0] cmd_rgb_in,
  input  logic        frame_end_in,
  output logic        valid_out,
  output logic [8:0]  x_out,
  output logic [7:0]  y_out,
  output logic [7:0]  z_out,
  output logic [11:0] rgb_out,
  output logic        switch_out,
  output logic        busy_out
);

  localparam logic [8:0] X_LAST = 9'(WIDTH - 1);
  localparam logic [7:0] Y_LAST = 8'(HEIGHT - 1);

  typedef enum logic [1:0] {IDLE, SCAN, SWITCH} state_t;

  state_t      state, state_d;
  logic        pending, pending_d;
  logic [8:0]  xmin_r, xmax_r;
  logic [7:0]  ymax_r;
  logic [8:0]  cx_lo, cx_hi;
  logic [7:0]  cy_lo, cy_hi;
  logic        accept, reject, last_frag;
  logic        valid_d, switch_d, busy_d;
  logic [8:0]  x_d;
  logic [7:0]  y_d, z_d;
  logic [11:0] rgb_d;

  function automatic logic [8:0] min9(input logic [8:0] a, input logic [8:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [8:0] max9(input logic [8:0] a, input logic [8:0] b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [7:0] min8(input logic [7:0] a, input logic [7:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [7:0] max8(input logic [7:0] a, input logic [7:0] b);
    return (a > b) ? a : b;
  endfunction

  assign cx_lo     = min9(cmd_x0_in, cmd_x1_in);
  assign cx_hi     = min9(max9(cmd_x0_in, cmd_x1_in), X_LAST);
  assign cy_lo     = min8(cmd_y0_in, cmd_y1_in);
  assign cy_hi     = min8(max8(cmd_y0_in, cmd_y1_in), Y_LAST);
  // A rectangle lying entirely off-screen is consumed without producing fragments.
  assign reject    = (cx_lo > X_LAST) || (cy_lo > Y_LAST);
  assign cmd_ready_out = (state == IDLE) && !pending;
  assign accept    = cmd_valid_in && cmd_ready_out;
  assign last_frag = (x_out == xmax_r) && (y_out == ymax_r);

  always_ff @(posedge gpu_clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state   <= IDLE;
      pending <= 1'b0;
    end else begin
      state   <= state_d;
      pending <= pending_d;
    end
  end

  always_comb begin
    state_d   = state;
    pending_d = frame_end_in || (pending && (state != SWITCH));
    case (state)
      IDLE: begin
        if (accept && !reject)              state_d = SCAN;
        else if (pending || frame_end_in)   state_d = SWITCH;
      end
      SCAN:    if (last_frag) state_d = pending ? SWITCH : IDLE;
      SWITCH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    valid_d  = 1'b0;
    x_d      = x_out;
    y_d      = y_out;
    z_d      = z_out;
    rgb_d    = rgb_out;
    switch_d = (state_d == SWITCH);
    busy_d   = (state_d != IDLE) || pending_d;
    if (state == IDLE && accept && !reject) begin
      valid_d = 1'b1;
      x_d     = cx_lo;
      y_d     = cy_lo;
      z_d     = cmd_z_in;
      rgb_d   = cmd_rgb_in;
    end else if (state == SCAN && !last_frag) begin
      valid_d = 1'b1;
      if (x_out == xmax_r) begin
        x_d = xmin_r;
        y_d = y_out + 8'd1;
      end else begin
        x_d = x_out + 9'd1;
      end
    end
  end

  always_ff @(posedge gpu_clk_in or negedge rst_in) begin
    if (!rst_in) begin
      valid_out  <= 1'b0;
      x_out      <= '0;
      y_out      <= '0;
      z_out      <= '0;
      rgb_out    <= '0;
      switch_out <= 1'b0;
      busy_out   <= 1'b0;
    end else begin
      valid_out  <= valid_d;
      x_out      <= x_d;
      y_out      <= y_d;
      z_out      <= z_d;
      rgb_out    <= rgb_d;
      switch_out <= switch_d;
      busy_out   <= busy_d;
    end
  end

  // Scan bounds only matter while SCAN is active, so they carry no reset.
  always_ff @(posedge gpu_clk_in) begin
    if (accept) begin
      xmin_r <= cx_lo;
      xmax_r <= cx_hi;
      ymax_r <= cy_hi;
    end
  end

endmodule
